// File: rtl/inst_decode_stage.sv
// RV32I decode stage. Decodes up to FETCH_WIDTH instructions per cycle from the
// fetch buffer and holds the decoded bundle in an output register that is
// handed to rename/dispatch with a valid/ready handshake.
module inst_decode_stage #(
    parameter int FETCH_WIDTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [FETCH_WIDTH*32-1:0] in_pc,
    input  logic [FETCH_WIDTH*32-1:0] in_inst,
    input  logic [FETCH_WIDTH-1:0]    in_valid,
    output logic                     in_ready,
    output logic [FETCH_WIDTH-1:0]    out_valid,
    input  logic                     out_ready,
    output logic [FETCH_WIDTH*32-1:0] out_pc,
    output logic [FETCH_WIDTH*32-1:0] out_imm,
    output logic [FETCH_WIDTH*5-1:0]  out_rs1,
    output logic [FETCH_WIDTH*5-1:0]  out_rs2,
    output logic [FETCH_WIDTH*5-1:0]  out_rd,
    output logic [FETCH_WIDTH-1:0]    out_rs1_en,
    output logic [FETCH_WIDTH-1:0]    out_rs2_en,
    output logic [FETCH_WIDTH-1:0]    out_rd_en,
    output logic [FETCH_WIDTH*4-1:0]  out_class,
    output logic [FETCH_WIDTH*4-1:0]  out_alu_op,
    output logic [FETCH_WIDTH*3-1:0]  out_funct3,
    output logic [FETCH_WIDTH-1:0]    out_illegal
);

    typedef enum logic [3:0] {
        CLASS_ALU_R   = 4'd0,
        CLASS_ALU_I   = 4'd1,
        CLASS_LOAD    = 4'd2,
        CLASS_STORE   = 4'd3,
        CLASS_BRANCH  = 4'd4,
        CLASS_JAL     = 4'd5,
        CLASS_JALR    = 4'd6,
        CLASS_LUI     = 4'd7,
        CLASS_AUIPC   = 4'd8,
        CLASS_SYSTEM  = 4'd9,
        CLASS_ILLEGAL = 4'd15
    } inst_class_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [3:0]  cls;
        logic [3:0]  alu_op;
        logic [31:0] imm;
        logic        illegal;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_en;
    } decode_t;

    decode_t slot_dec [FETCH_WIDTH];
    logic    accept;

    // Base ALU op selected by funct3; bit 30 picks arithmetic right shift.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic bit30);
        alu_op_e op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Full decode of one instruction word; slot_valid only gates the enables
    // so that invalid slots still decode deterministically.
    function automatic decode_t decode_inst(input logic [31:0] inst, input logic slot_valid);
        decode_t     d;
        inst_class_e cls;
        logic        bad;
        logic        live;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        opcode = inst[6:0];
        funct3 = inst[14:12];
        funct7 = inst[31:25];
        imm_i  = {{20{inst[31]}}, inst[31:20]};
        imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u  = {inst[31:12], 12'b0};
        imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        d        = '0;
        d.alu_op = ALU_ADD;
        cls      = CLASS_ILLEGAL;
        bad      = 1'b0;
        case (opcode)
            7'b0110011: begin
                cls      = CLASS_ALU_R;
                d.alu_op = alu_from_funct3(funct3, inst[30]);
                if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      d.alu_op = ALU_SUB;
                    else if (funct3 != 3'b101) bad = 1'b1;
                end else if (funct7 != 7'b0000000) begin
                    bad = 1'b1;
                end
            end
            7'b0010011: begin
                cls      = CLASS_ALU_I;
                d.imm    = imm_i;
                d.alu_op = alu_from_funct3(funct3, inst[30]);
                if (funct3 == 3'b001 && funct7 != 7'b0000000) bad = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) bad = 1'b1;
            end
            7'b0000011: begin
                cls   = CLASS_LOAD;
                d.imm = imm_i;
                bad   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            7'b0100011: begin
                cls   = CLASS_STORE;
                d.imm = imm_s;
                bad   = (funct3 > 3'b010);
            end
            7'b1100011: begin
                cls   = CLASS_BRANCH;
                d.imm = imm_b;
                bad   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            7'b1101111: begin
                cls   = CLASS_JAL;
                d.imm = imm_j;
            end
            7'b1100111: begin
                cls   = CLASS_JALR;
                d.imm = imm_i;
                bad   = (funct3 != 3'b000);
            end
            7'b0110111: begin
                cls   = CLASS_LUI;
                d.imm = imm_u;
            end
            7'b0010111: begin
                cls   = CLASS_AUIPC;
                d.imm = imm_u;
            end
            7'b1110011, 7'b0001111: begin
                cls   = CLASS_SYSTEM;
                d.imm = imm_i;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            cls      = CLASS_ILLEGAL;
            d.alu_op = ALU_ADD;
        end
        live      = slot_valid && !bad;
        d.cls     = cls;
        d.illegal = bad;
        d.rs1_en  = live && (cls inside {CLASS_ALU_R, CLASS_ALU_I, CLASS_LOAD,
                                         CLASS_STORE, CLASS_BRANCH, CLASS_JALR});
        d.rs2_en  = live && (cls inside {CLASS_ALU_R, CLASS_STORE, CLASS_BRANCH});
        d.rd_en   = live && (inst[11:7] != 5'd0) &&
                    (cls inside {CLASS_ALU_R, CLASS_ALU_I, CLASS_LOAD, CLASS_JAL,
                                 CLASS_JALR, CLASS_LUI, CLASS_AUIPC});
        return d;
    endfunction

    // The register can take a new bundle when empty or when the held one drains.
    assign in_ready = !reset && !flush && ((out_valid == '0) || out_ready);
    assign accept   = in_ready && (|in_valid);

    // Decode every incoming slot in parallel.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_dec[i] = decode_inst(in_inst[32*i +: 32], in_valid[i]);
        end
    end

    // Output pipeline register: flush beats everything, then load or drain.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= '0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_rs1_en  <= '0;
            out_rs2_en  <= '0;
            out_rd_en   <= '0;
            out_class   <= '0;
            out_alu_op  <= '0;
            out_funct3  <= '0;
            out_illegal <= '0;
        end else if (flush) begin
            out_valid <= '0;
        end else if (accept) begin
            out_valid <= in_valid;
            out_pc    <= in_pc;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                out_imm[32*i +: 32] <= slot_dec[i].imm;
                out_rs1[5*i +: 5]   <= in_inst[32*i+15 +: 5];
                out_rs2[5*i +: 5]   <= in_inst[32*i+20 +: 5];
                out_rd[5*i +: 5]    <= in_inst[32*i+7 +: 5];
                out_rs1_en[i]       <= slot_dec[i].rs1_en;
                out_rs2_en[i]       <= slot_dec[i].rs2_en;
                out_rd_en[i]        <= slot_dec[i].rd_en;
                out_class[4*i +: 4] <= slot_dec[i].cls;
                out_alu_op[4*i +: 4] <= slot_dec[i].alu_op;
                out_funct3[3*i +: 3] <= in_inst[32*i+12 +: 3];
                out_illegal[i]      <= slot_dec[i].illegal;
            end
        end else if (in_ready) begin
            out_valid <= '0;
        end
    end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed steps followed by random
// traffic, compared against a behavioural model of the decode rules and handshake.
module tb_inst_decode_stage;

    localparam int FW = 2;
    localparam int ALU_OF_F3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    localparam int OPCODES [11] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6F, 'h67, 'h37, 'h17, 'h73, 'h0F};

    logic            clock;
    logic            reset;
    logic            flush;
    logic [FW*32-1:0] in_pc;
    logic [FW*32-1:0] in_inst;
    logic [FW-1:0]    in_valid;
    logic            in_ready;
    logic [FW-1:0]    out_valid;
    logic            out_ready;
    logic [FW*32-1:0] out_pc;
    logic [FW*32-1:0] out_imm;
    logic [FW*5-1:0]  out_rs1;
    logic [FW*5-1:0]  out_rs2;
    logic [FW*5-1:0]  out_rd;
    logic [FW-1:0]    out_rs1_en;
    logic [FW-1:0]    out_rs2_en;
    logic [FW-1:0]    out_rd_en;
    logic [FW*4-1:0]  out_class;
    logic [FW*4-1:0]  out_alu_op;
    logic [FW*3-1:0]  out_funct3;
    logic [FW-1:0]    out_illegal;

    typedef struct {
        int          cls;
        int          alu;
        logic [31:0] imm;
        bit          illegal;
        bit          rs1e;
        bit          rs2e;
        bit          rde;
    } ref_t;

    int          n_checks;
    int          n_fails;
    logic [1:0]  m_valid;
    logic [31:0] m_inst [FW];
    logic [31:0] m_pc [FW];
    bit          m_zero;
    logic [31:0] next_pc;

    inst_decode_stage #(.FETCH_WIDTH(FW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_pc(in_pc), .in_inst(in_inst), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_en(out_rd_en),
        .out_class(out_class), .out_alu_op(out_alu_op), .out_funct3(out_funct3),
        .out_illegal(out_illegal)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Interpret an unsigned field of the given width as two's complement.
    function automatic logic [31:0] sext(input longint v, input int bits);
        longint r;
        r = v;
        if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
        return r[31:0];
    endfunction

    // Behavioural RV32I decode following the instruction-set rules directly.
    function automatic ref_t refDecode(input logic [31:0] inst, input bit slot_valid);
        ref_t r;
        int   op, f3, f7;
        bit   live;
        op = int'(inst[6:0]);
        f3 = int'(inst[14:12]);
        f7 = int'(inst[31:25]);
        r.cls = 15; r.alu = 0; r.imm = 32'd0; r.illegal = 1'b0;
        case (op)
            'h33: begin
                r.cls = 0;
                r.alu = ALU_OF_F3[f3];
                if (f7 == 32) begin
                    if (f3 == 0)      r.alu = 1;
                    else if (f3 == 5) r.alu = 7;
                    else              r.illegal = 1'b1;
                end else if (f7 != 0) r.illegal = 1'b1;
            end
            'h13: begin
                r.cls = 1;
                r.imm = sext(longint'(inst[31:20]), 12);
                r.alu = ALU_OF_F3[f3];
                if (f3 == 5 && f7 == 32) r.alu = 7;
                if (f3 == 1 && f7 != 0) r.illegal = 1'b1;
                if (f3 == 5 && !(f7 inside {0, 32})) r.illegal = 1'b1;
            end
            'h03: begin
                r.cls = 2;
                r.imm = sext(longint'(inst[31:20]), 12);
                r.illegal = (f3 inside {3, 6, 7});
            end
            'h23: begin
                r.cls = 3;
                r.imm = sext(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
                r.illegal = (f3 > 2);
            end
            'h63: begin
                r.cls = 4;
                r.imm = sext(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
                             longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
                r.illegal = (f3 inside {2, 3});
            end
            'h6F: begin
                r.cls = 5;
                r.imm = sext(longint'(inst[31]) * (1 << 20) + longint'(inst[19:12]) * (1 << 12) +
                             longint'(inst[20]) * (1 << 11) + longint'(inst[30:21]) * 2, 21);
            end
            'h67: begin
                r.cls = 6;
                r.imm = sext(longint'(inst[31:20]), 12);
                r.illegal = (f3 != 0);
            end
            'h37: begin r.cls = 7; r.imm = inst & 32'hFFFFF000; end
            'h17: begin r.cls = 8; r.imm = inst & 32'hFFFFF000; end
            'h73, 'h0F: begin
                r.cls = 9;
                r.imm = sext(longint'(inst[31:20]), 12);
            end
            default: r.illegal = 1'b1;
        endcase
        if (r.illegal) begin
            r.cls = 15;
            r.alu = 0;
        end
        live   = slot_valid && !r.illegal;
        r.rs1e = live && (r.cls inside {0, 1, 2, 3, 4, 6});
        r.rs2e = live && (r.cls inside {0, 3, 4});
        r.rde  = live && (inst[11:7] != 0) && (r.cls inside {0, 1, 2, 5, 6, 7, 8});
        return r;
    endfunction

    // One counted comparison.
    task automatic checkField(input string tag, input int slot, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s slot%0d observed=%h expected=%h", tag, slot, obs, exp);
        end
    endtask

    // Drive one cycle worth of inputs; PCs come from a running counter.
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        in_inst   = {i1, i0};
        in_pc     = {next_pc + 32'd4, next_pc};
        out_ready = rdy;
        flush     = fl;
    endtask

    // Compare in_ready and the held bundle against the model.
    task automatic checkOutput();
        ref_t        r;
        logic        exp_ready;
        logic [31:0] e_pc, e_imm;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [2:0]  e_f3;
        exp_ready = !reset && !flush && (m_valid == 2'b00 || out_ready);
        checkField("in_ready", -1, 32'(in_ready), 32'(exp_ready));
        checkField("out_valid", -1, 32'(out_valid), 32'(m_valid));
        if (m_zero || m_valid != 2'b00) begin
            for (int s = 0; s < FW; s++) begin
                if (m_zero) begin
                    r = '{cls: 0, alu: 0, imm: 32'd0, illegal: 1'b0, rs1e: 1'b0, rs2e: 1'b0, rde: 1'b0};
                    e_pc = 32'd0; e_rs1 = 5'd0; e_rs2 = 5'd0; e_rd = 5'd0; e_f3 = 3'd0;
                end else begin
                    r     = refDecode(m_inst[s], m_valid[s]);
                    e_pc  = m_pc[s];
                    e_rs1 = m_inst[s][19:15];
                    e_rs2 = m_inst[s][24:20];
                    e_rd  = m_inst[s][11:7];
                    e_f3  = m_inst[s][14:12];
                end
                checkField("pc", s, out_pc[32*s +: 32], e_pc);
                checkField("rs1", s, 32'(out_rs1[5*s +: 5]), 32'(e_rs1));
                checkField("rs2", s, 32'(out_rs2[5*s +: 5]), 32'(e_rs2));
                checkField("rd", s, 32'(out_rd[5*s +: 5]), 32'(e_rd));
                checkField("funct3", s, 32'(out_funct3[3*s +: 3]), 32'(e_f3));
                checkField("class", s, 32'(out_class[4*s +: 4]), 32'(r.cls));
                checkField("illegal", s, 32'(out_illegal[s]), 32'(r.illegal));
                checkField("rs1_en", s, 32'(out_rs1_en[s]), 32'(r.rs1e));
                checkField("rs2_en", s, 32'(out_rs2_en[s]), 32'(r.rs2e));
                checkField("rd_en", s, 32'(out_rd_en[s]), 32'(r.rde));
                if (!r.illegal) begin
                    checkField("imm", s, out_imm[32*s +: 32], r.imm);
                    checkField("alu_op", s, 32'(out_alu_op[4*s +: 4]), 32'(r.alu));
                end
            end
        end
    endtask

    // Check just before the edge, then advance the model across the edge.
    task automatic stepCycle();
        logic exp_ready;
        #3;
        checkOutput();
        exp_ready = !reset && !flush && (m_valid == 2'b00 || out_ready);
        @(posedge clock);
        if (reset) begin
            m_valid = 2'b00;
            m_zero  = 1'b1;
        end else if (flush) begin
            m_valid = 2'b00;
        end else if (exp_ready && in_valid != 2'b00) begin
            m_valid  = in_valid;
            m_inst[0] = in_inst[31:0];
            m_inst[1] = in_inst[63:32];
            m_pc[0]  = in_pc[31:0];
            m_pc[1]  = in_pc[63:32];
            m_zero   = 1'b0;
            next_pc  = next_pc + 32'd8;
        end else if (exp_ready) begin
            m_valid = 2'b00;
        end
        #1;
    endtask

    // Random instruction biased towards legal opcodes and legal funct7 values.
    function automatic logic [31:0] randInst();
        logic [31:0] r;
        int          op;
        r = $urandom;
        if ($urandom_range(7) == 0) return r;
        op = OPCODES[$urandom_range(10)];
        r[6:0] = op[6:0];
        if ((op == 'h33 || op == 'h13) && $urandom_range(3) != 0)
            r[31:25] = ($urandom_range(1) == 1) ? 7'b0100000 : 7'b0000000;
        return r;
    endfunction

    // Linear sequence of directed steps followed by random traffic.
    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_valid  = 2'b00;
        m_zero   = 1'b1;
        m_inst   = '{default: 32'd0};
        m_pc     = '{default: 32'd0};
        next_pc  = 32'h0000_1000;
        reset    = 1'b1;
        applyStimulus(2'b11, 32'h00500093, 32'h402081B3, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        stepCycle();
        reset = 1'b0;

        $display("[TB] addi/sub bundle");
        applyStimulus(2'b11, 32'h00500093, 32'h402081B3, 1'b1, 1'b0);
        stepCycle();
        checkField("tp1_valid", -1, 32'(out_valid), 32'd3);
        checkField("tp1_class", 0, 32'(out_class[3:0]), 32'd1);
        checkField("tp1_imm", 0, out_imm[31:0], 32'd5);
        checkField("tp1_rd", 0, 32'(out_rd[4:0]), 32'd1);
        checkField("tp1_rs2en", 0, 32'(out_rs2_en[0]), 32'd0);
        checkField("tp1_class", 1, 32'(out_class[7:4]), 32'd0);
        checkField("tp1_alu", 1, 32'(out_alu_op[7:4]), 32'd1);
        checkField("tp1_rd", 1, 32'(out_rd[9:5]), 32'd3);

        $display("[TB] beq/sw bundle");
        applyStimulus(2'b11, 32'hFE208CE3, 32'h00512623, 1'b1, 1'b0);
        stepCycle();
        checkField("tp2_class", 0, 32'(out_class[3:0]), 32'd4);
        checkField("tp2_imm", 0, out_imm[31:0], 32'hFFFFFFF8);
        checkField("tp2_rden", 0, 32'(out_rd_en[0]), 32'd0);
        checkField("tp2_class", 1, 32'(out_class[7:4]), 32'd3);
        checkField("tp2_imm", 1, out_imm[63:32], 32'd12);
        checkField("tp2_rs2", 1, 32'(out_rs2[9:5]), 32'd5);
        checkField("tp2_funct3", 1, 32'(out_funct3[5:3]), 32'd2);

        $display("[TB] backpressure");
        applyStimulus(2'b11, 32'h123453B7, 32'h00000000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkField("bp_hold_class", 0, 32'(out_class[3:0]), 32'd4);
        end
        applyStimulus(2'b11, 32'h123453B7, 32'h00000000, 1'b1, 1'b0);
        stepCycle();
        checkField("tp3_class", 0, 32'(out_class[3:0]), 32'd7);
        checkField("tp3_imm", 0, out_imm[31:0], 32'h12345000);
        checkField("tp3_illegal", 1, 32'(out_illegal[1]), 32'd1);
        checkField("tp3_class", 1, 32'(out_class[7:4]), 32'd15);

        $display("[TB] flush");
        applyStimulus(2'b11, 32'h00000013, 32'h00000013, 1'b1, 1'b1);
        stepCycle();
        checkField("flush_valid", -1, 32'(out_valid), 32'd0);
        applyStimulus(2'b11, 32'h00000013, 32'h00000013, 1'b1, 1'b0);
        stepCycle();
        checkField("nop_rden", 0, 32'(out_rd_en[0]), 32'd0);

        $display("[TB] slot1 only, then drain");
        applyStimulus(2'b10, 32'h00000000, 32'h00A00293, 1'b1, 1'b0);
        stepCycle();
        checkField("s1only_valid", -1, 32'(out_valid), 32'd2);
        checkField("s1only_rden", 1, 32'(out_rd_en[1]), 32'd1);
        applyStimulus(2'b00, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
        stepCycle();
        checkField("drain_valid", -1, 32'(out_valid), 32'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(2'($urandom_range(3)), randInst(), randInst(),
                          ($urandom_range(3) != 0), ($urandom_range(19) == 0));
            stepCycle();
        end
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
        stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
